// File: rtl/game_timer.sv
// rtl/game_timer.sv - prescaled countdown timer issuing a one-cycle timeUp pulse on expiry
// Loads an 11-bit tick count on requestTime and counts TICK_DIV clk cycles per tick.
module game_timer #(
  parameter int TICK_DIV = 833333
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        requestTime,
  input  logic [10:0] slowClkRequest,
  input  logic        hold,
  input  logic        cancel,
  output logic        timeUp,
  output logic        busy,
  output logic [10:0] remaining,
  output logic        tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [10:0]     remaining_q, remaining_d;
  logic            busy_q, timeup_q;
  logic            tick_raw;

  assign tick_raw = (state_q == COUNT) && !hold && (presc_q == PW'(TICK_DIV - 1));
  // A cancel or reload in the same cycle overrides the decrement, so no tick is reported.
  assign tick     = tick_raw && !cancel && !requestTime;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    if (cancel) begin
      state_d     = IDLE;
      presc_d     = '0;
      remaining_d = '0;
    end else if (requestTime) begin
      presc_d     = '0;
      remaining_d = slowClkRequest;
      state_d     = (slowClkRequest != 11'd0) ? COUNT : DONE;
    end else begin
      case (state_q)
        IDLE: presc_d = '0;
        COUNT: begin
          if (!hold) begin
            if (tick_raw) begin
              presc_d = '0;
              if (remaining_q <= 11'd1) begin
                remaining_d = '0;
                state_d     = DONE;
              end else begin
                remaining_d = remaining_q - 11'd1;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          presc_d = '0;
        end
        default: begin
          state_d     = IDLE;
          presc_d     = '0;
          remaining_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      timeup_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      busy_q      <= (state_d == COUNT);
      timeup_q    <= (state_d == DONE);
    end
  end

  assign timeUp    = timeup_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - directed self-checking bench for game_timer with TICK_DIV=4
module tb_game_timer;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        requestTime = 1'b0;
  logic [10:0] slowClkRequest = '0;
  logic        hold = 1'b0;
  logic        cancel = 1'b0;
  logic        timeUp, busy, tick;
  logic [10:0] remaining;

  int tests_run = 0;
  int tests_failed = 0;

  game_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .resetN(resetN), .requestTime(requestTime),
    .slowClkRequest(slowClkRequest), .hold(hold), .cancel(cancel),
    .timeUp(timeUp), .busy(busy), .remaining(remaining), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of cycle 0, i.e. the cycle after request edge E0.
  task automatic req(input int n);
    @(negedge clk);
    requestTime    = 1'b1;
    slowClkRequest = 11'(n);
    @(posedge clk);
    @(negedge clk);
    requestTime    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " timeUp"}, int'(timeUp), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " remaining"}, int'(remaining), 0);
    check({tag, " tick"}, int'(tick), 0);
  endtask

  initial begin
    int first_up;
    int up_count;

    // 1: reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check_all_zero($sformatf("idle c%0d", c));
      @(negedge clk);
    end

    // 2: N=3 basic countdown
    req(3);
    for (int c = 0; c < 16; c++) begin
      check($sformatf("n3 rem c%0d", c), int'(remaining), (c < 4) ? 3 : (c < 8) ? 2 : (c < 12) ? 1 : 0);
      check($sformatf("n3 tick c%0d", c), int'(tick), ((c % 4 == 3) && c < 12) ? 1 : 0);
      check($sformatf("n3 timeUp c%0d", c), int'(timeUp), (c == 12) ? 1 : 0);
      check($sformatf("n3 busy c%0d", c), int'(busy), (c < 12) ? 1 : 0);
      @(negedge clk);
    end

    // 3a: N=0 expires immediately
    req(0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("n0 timeUp c%0d", c), int'(timeUp), (c == 0) ? 1 : 0);
      check($sformatf("n0 busy c%0d", c), int'(busy), 0);
      @(negedge clk);
    end

    // 3b: N=2047 maximum load
    req(2047);
    check("n2047 rem start", int'(remaining), 2047);
    first_up = -1;
    for (int c = 0; c < 8300 && first_up < 0; c++) begin
      if (timeUp) first_up = c;
      else @(negedge clk);
    end
    check("n2047 timeUp cycle", first_up, 8188);
    repeat (3) @(negedge clk);

    // 4: retrigger with N=2 at edge 6
    req(3);
    first_up = -1;
    for (int c = 0; c < 30; c++) begin
      if (timeUp && first_up < 0) first_up = c;
      requestTime    = (c == 5);
      slowClkRequest = (c == 5) ? 11'd2 : 11'd0;
      @(negedge clk);
    end
    check("retrig timeUp cycle", first_up, 14);

    // 5a: hold cycles 2..6 delays expiry by 5
    req(3);
    first_up = -1;
    up_count = 0;
    for (int c = 0; c < 30; c++) begin
      if (timeUp) begin
        up_count++;
        if (first_up < 0) first_up = c;
      end
      hold = (c >= 2 && c <= 6);
      @(negedge clk);
    end
    check("hold timeUp cycle", first_up, 17);
    check("hold timeUp width", up_count, 1);

    // 5b: cancel at cycle 6
    req(3);
    for (int c = 0; c < 7; c++) begin
      cancel = (c == 6);
      @(negedge clk);
    end
    cancel = 1'b0;
    check("cancel remaining", int'(remaining), 0);
    check("cancel busy", int'(busy), 0);
    up_count = 0;
    for (int c = 0; c < 50; c++) begin
      if (timeUp) up_count++;
      @(negedge clk);
    end
    check("cancel no timeUp", up_count, 0);

    // 6: async reset mid-count, then N=1
    req(3);
    repeat (5) @(negedge clk);
    check("prereset busy", int'(busy), 1);
    resetN = 1'b0;
    #1;
    check_all_zero("inreset");
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    up_count = 0;
    for (int c = 0; c < 50; c++) begin
      if (timeUp || busy) up_count++;
      @(negedge clk);
    end
    check("postreset quiet", up_count, 0);
    req(1);
    first_up = -1;
    for (int c = 0; c < 20 && first_up < 0; c++) begin
      if (timeUp) first_up = c;
      else @(negedge clk);
    end
    check("n1 timeUp cycle", first_up, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/game_timer.md
# game_timer

Countdown timer serving the game-state FSM's transition timing requests. On a `requestTime` strobe it latches an 11-bit tick count from `slowClkRequest`. It then counts that many prescaled ticks derived from `clk`, and returns a single-cycle `timeUp` pulse, which the top level wires to the FSM's `slowClk` input. It also exposes busy/remaining status for screen overlays, e.g. an inter-level countdown.

## Interface
- `TICK_DIV`, default 833333: `clk` cycles per timer tick (50 MHz / 60, one tick per frame). Legal range ≥ 2.
- `clk`  in  1  system clock.
- `resetN`  in  1  reset, asynchronous, active-low.
- `requestTime`  in  1  load/start strobe. Sampled every cycle.
- `slowClkRequest`  in  11  tick count to load. Valid when `requestTime`=1.
- `hold`  in  1  freeze countdown (prescaler and count) while 1.
- `cancel`  in  1  abort countdown, no `timeUp`.
- `timeUp`  out  1  registered, one-cycle pulse on expiry.
- `busy`  out  1  registered, 1 while counting.
- `remaining`  out  11  registered, ticks left.
- `tick`  out  1  combinational, 1 in the cycle a decrement occurs.

## Operation
- States: IDLE, COUNT, DONE. The state is registered; the prescaler is a register of width $clog2(TICK_DIV).
- Reset (async): state=IDLE, prescaler=0, `remaining`=0, `busy`=0, `timeUp`=0. This applies equally mid-count. A countdown interrupted by reset never produces `timeUp`.
- Per-cycle priority: `cancel` > `requestTime` > tick decrement.
- `cancel`=1 (any state): next state IDLE, `remaining`=0, prescaler=0. A pending expiry is suppressed.
- `requestTime`=1 with N=`slowClkRequest`:
  - N>0: `remaining`←N, prescaler←0, next state COUNT.
  - N=0: next state DONE, `remaining`←0.
- Retrigger: `requestTime` in COUNT or DONE reloads and restarts per the rule above. A level-held `requestTime` reloads every cycle, so the countdown effectively starts at the last cycle of assertion.
- In COUNT with `hold`=0:
  - The prescaler increments each cycle.
  - `tick`=1 when prescaler==TICK_DIV-1. On that edge the prescaler wraps to 0 and `remaining` decrements.
  - If `remaining`==1 at the tick, `remaining`←0 and next state is DONE.
- `hold`=1 in COUNT: prescaler and `remaining` are frozen and `tick`=0. `cancel` and `requestTime` still act.
- DONE lasts exactly one cycle. Next state is IDLE, unless `requestTime` or `cancel` applies.
- IDLE: prescaler held at 0; `tick`=0.
- Output decode (registered from next state):
  - `busy`=1 iff state==COUNT.
  - `timeUp`=1 iff state==DONE.
- Width rules: `remaining` is 11-bit unsigned, max 2047. It never underflows, because a decrement occurs only when `remaining`≥1.

## Timing
- Request sampled at edge E0 with N>0:
  - Decrements at edges E0+k·TICK_DIV, for k=1..N.
  - `timeUp` is high during the cycle after edge E0+N·TICK_DIV.
  - Latency from request edge to `timeUp` rising is N·TICK_DIV cycles.
  - `busy` rises after E0 and falls in the same edge `timeUp` rises.
- N=0: `timeUp` is high in the cycle after E0 (1-cycle latency). `busy` stays 0.
- Each `hold` cycle delays expiry by exactly one cycle.
- Simultaneous `requestTime` and expiry tick: the reload wins and no `timeUp` is issued.
- `requestTime` during DONE: `timeUp` still completes its one cycle, and the new countdown starts from that edge.
- `timeUp` is never wider than 1 cycle. Consecutive `timeUp` pulses are separated by ≥1 low cycle, unless consecutive N=0 requests occur.

## Test plan
All scenarios use TICK_DIV=4.
1. Reset, then idle 20 cycles → `timeUp`=0, `busy`=0, `remaining`=0, `tick`=0 throughout.
2. `requestTime` 1 cycle with N=3 at edge 0 → `remaining` reads 3/2/1/0 after edges 0/4/8/12. `tick` is high in cycles 3, 7 and 11. `timeUp` is high only in cycle 12. `busy` is high in cycles 0-11.
3. N=0 request → `timeUp` high the next cycle only, `busy` never high. N=2047 → `remaining` starts at 2047 and `timeUp` rises after 8188 cycles.
4. N=3 at edge 0, then a retrigger with N=2 at edge 6 → no expiry at 12; `timeUp` high at cycle 14.
5. N=3 with `hold` high for 5 cycles starting at cycle 2 → `timeUp` at cycle 17. Separately, `cancel` at cycle 6 → `remaining`=0, `busy`=0, and no `timeUp` within 50 cycles.
6. N=3 started, `resetN` low at cycle 5 for 2 cycles → all outputs 0 immediately, and no `timeUp` within 50 cycles after release. A subsequent N=1 request yields `timeUp` 4 cycles after its request edge.
